// File: rtl/clkdiv_pkg.sv
// Shared constants for the programmable clock-enable divider.
// No logic; latency not applicable.
// No flow control; constants only.
package clkdiv_pkg;

  // Output mode encodings.
  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

  // Smallest divisor that still yields a distinct tick and a square wave.
  localparam int unsigned MIN_DIV = 2;

  // Standard divisors used by the top level for slow enables off 100 MHz.
  localparam int unsigned DIV_1KHZ = 100000;
  localparam int unsigned DIV_1HZ  = 100000000;

endpackage

// File: rtl/clkdiv_cfg_shadow.sv
// Pending/active divisor+mode shadow pair with clamp, sticky error and boundary apply.
// Latency: a load reaches active one edge after the first tc or frozen cycle.
// No backpressure: loads are never refused; a newer pending load overwrites the older one.
module clkdiv_cfg_shadow
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEFAULT_DIV  = DIV_1KHZ,
  parameter logic        DEFAULT_MODE = MODE_PULSE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             tc,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] div_value,
  input  logic             mode_value,
  output logic [WIDTH-1:0] active_div,
  output logic             active_mode,
  output logic             next_mode,
  output logic             apply_fire,
  output logic             cfg_pending,
  output logic             cfg_err
);

  logic [WIDTH-1:0] pend_div;
  logic             pend_mode;
  logic             div_bad;
  logic [WIDTH-1:0] load_div;
  logic             apply_now;
  logic [WIDTH-1:0] apply_div;
  logic             apply_mode;

  // Clamp the presented divisor and decide what, if anything, becomes active this edge.
  // A load arriving in an apply cycle bypasses the pending register entirely.
  always_comb begin
    div_bad    = (div_value < WIDTH'(MIN_DIV));
    load_div   = div_bad ? WIDTH'(MIN_DIV) : div_value;
    apply_now  = tc | ~enable;
    apply_fire = apply_now & (cfg_load | cfg_pending);
    apply_div  = cfg_load ? load_div   : pend_div;
    apply_mode = cfg_load ? mode_value : pend_mode;
    next_mode  = apply_fire ? apply_mode : active_mode;
  end

  // Shadow registers: reset to defaults, latch loads, promote pending at boundaries.
  always_ff @(posedge clock) begin
    if (!reset) begin
      active_div  <= WIDTH'(DEFAULT_DIV);
      active_mode <= DEFAULT_MODE;
      pend_div    <= WIDTH'(DEFAULT_DIV);
      pend_mode   <= DEFAULT_MODE;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      if (cfg_load && div_bad) begin
        cfg_err <= 1'b1;
      end
      if (apply_fire) begin
        active_div  <= apply_div;
        active_mode <= apply_mode;
        cfg_pending <= 1'b0;
      end else if (cfg_load) begin
        pend_div    <= load_div;
        pend_mode   <= mode_value;
        cfg_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock-enable generator: registered tick (pulse) or divided level (square).
// Latency: tick_out/clock_out are registered, 1 cycle after the counter condition.
// No backpressure: enable=0 freezes the counter; config loads are held until a period boundary.
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEFAULT_DIV  = DIV_1KHZ,
  parameter logic        DEFAULT_MODE = MODE_PULSE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_value,
  input  logic             mode_value,
  input  logic             cfg_load,
  output logic             tick_out,
  output logic             clock_out,
  output logic [WIDTH-1:0] count,
  output logic             cfg_pending,
  output logic             cfg_err
);

  logic [WIDTH-1:0] active_div;
  logic [WIDTH-1:0] half_div;
  logic             active_mode;
  logic             next_mode;
  logic             apply_fire;
  logic             tc;
  logic             half_hit;

  clkdiv_cfg_shadow #(
    .WIDTH        (WIDTH),
    .DEFAULT_DIV  (DEFAULT_DIV),
    .DEFAULT_MODE (DEFAULT_MODE)
  ) u_cfg (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .tc          (tc),
    .cfg_load    (cfg_load),
    .div_value   (div_value),
    .mode_value  (mode_value),
    .active_div  (active_div),
    .active_mode (active_mode),
    .next_mode   (next_mode),
    .apply_fire  (apply_fire),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err)
  );

  // Period boundary and mid-period (falling edge of square output) detection.
  always_comb begin
    half_div = active_div >> 1;
    tc       = enable & (count == active_div - WIDTH'(1));
    half_hit = enable & (count == half_div - WIDTH'(1));
  end

  // Counter: wrap at terminal count, hold when frozen, restart when a config lands while frozen.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (apply_fire && !enable) begin
      count <= '0;
    end else if (enable) begin
      count <= tc ? '0 : count + WIDTH'(1);
    end
  end

  // Pulse output: one cycle per period, only while the finishing period is in pulse mode.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tick_out <= 1'b0;
    end else begin
      tick_out <= tc & (active_mode == MODE_PULSE);
    end
  end

  // Square output: rise entering count 0 of a square period, fall entering count H.
  // The boundary uses the mode of the period about to start so a switch is glitch-free.
  always_ff @(posedge clock) begin
    if (!reset) begin
      clock_out <= 1'b0;
    end else if (tc) begin
      clock_out <= (next_mode == MODE_SQUARE);
    end else if (apply_fire && next_mode == MODE_PULSE) begin
      clock_out <= 1'b0;
    end else if (half_hit && active_mode == MODE_SQUARE) begin
      clock_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed table-driven bench for clock_divider_prog (WIDTH=8, DEFAULT_DIV=5, pulse default).
// Each row drives inputs, advances one clock edge, then compares all outputs 1 time unit later.
// Hand sequences afterwards cover load-on-terminal-count and a zero divisor loaded while frozen.
module tb_clock_divider_prog;

  localparam int unsigned W = 8;

  logic         clock;
  logic         reset;
  logic         enable;
  logic [W-1:0] div_value;
  logic         mode_value;
  logic         cfg_load;
  logic         tick_out;
  logic         clock_out;
  logic [W-1:0] count;
  logic         cfg_pending;
  logic         cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         rst_n;
    logic         en;
    logic         ld;
    logic [W-1:0] div;
    logic         mode;
    logic         tick;
    logic         clk;
    logic [W-1:0] cnt;
    logic         pend;
    logic         err;
  } vec_t;

  vec_t vecs[$];

  clock_divider_prog #(
    .WIDTH        (W),
    .DEFAULT_DIV  (5),
    .DEFAULT_MODE (1'b0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .div_value   (div_value),
    .mode_value  (mode_value),
    .cfg_load    (cfg_load),
    .tick_out    (tick_out),
    .clock_out   (clock_out),
    .count       (count),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", nm, row, act, exp);
    end
  endtask

  task automatic add(input int r, input int en, input int ld, input int dv, input int md,
                     input int tk, input int ck, input int cn, input int pd, input int er);
    vec_t v;
    v.rst_n = r[0];
    v.en    = en[0];
    v.ld    = ld[0];
    v.div   = W'(dv);
    v.mode  = md[0];
    v.tick  = tk[0];
    v.clk   = ck[0];
    v.cnt   = W'(cn);
    v.pend  = pd[0];
    v.err   = er[0];
    vecs.push_back(v);
  endtask

  task automatic chk_all(input int row, input int tk, input int ck, input int cn, input int pd, input int er);
    chk("tick_out",    row, 32'(tick_out),    32'(tk));
    chk("clock_out",   row, 32'(clock_out),   32'(ck));
    chk("count",       row, 32'(count),       32'(cn));
    chk("cfg_pending", row, 32'(cfg_pending), 32'(pd));
    chk("cfg_err",     row, 32'(cfg_err),     32'(er));
  endtask

  initial begin
    reset      = 1'b0;
    enable     = 1'b0;
    div_value  = '0;
    mode_value = 1'b0;
    cfg_load   = 1'b0;

    // Reset state, then default D=5 pulse: ticks every 5 cycles.
    add(0,0,0,0,0, 0,0,0,0,0);
    for (int k = 1; k <= 4; k++) add(1,1,0,0,0, 0,0,k,0,0);
    add(1,1,0,0,0, 1,0,0,0,0);
    for (int k = 1; k <= 4; k++) add(1,1,0,0,0, 0,0,k,0,0);
    add(1,1,0,0,0, 1,0,0,0,0);

    // Load D=6, then D=4 mid-period at count=2; both land on terminal count.
    add(1,1,1,6,0, 0,0,1,1,0);
    for (int k = 2; k <= 4; k++) add(1,1,0,0,0, 0,0,k,1,0);
    add(1,1,0,0,0, 1,0,0,0,0);
    for (int k = 1; k <= 2; k++) add(1,1,0,0,0, 0,0,k,0,0);
    add(1,1,1,4,0, 0,0,3,1,0);
    for (int k = 4; k <= 5; k++) add(1,1,0,0,0, 0,0,k,1,0);
    add(1,1,0,0,0, 1,0,0,0,0);
    for (int k = 1; k <= 3; k++) add(1,1,0,0,0, 0,0,k,0,0);
    add(1,1,0,0,0, 1,0,0,0,0);

    // D=1 clamps to 2 and sets sticky cfg_err; a later valid load keeps it set.
    add(1,1,1,1,0, 0,0,1,1,1);
    for (int k = 2; k <= 3; k++) add(1,1,0,0,0, 0,0,k,1,1);
    add(1,1,0,0,0, 1,0,0,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 1,0,0,0,1);
    add(1,1,1,7,0, 0,0,1,1,1);
    add(1,1,0,0,0, 1,0,0,0,1);

    // Switch to square D=5: 1,1,0,0,0 by count; then D=4: 1,1,0,0; then back to pulse D=8.
    add(1,1,1,5,1, 0,0,1,1,1);
    for (int k = 2; k <= 6; k++) add(1,1,0,0,0, 0,0,k,1,1);
    add(1,1,0,0,0, 1,1,0,0,1);
    for (int rep = 0; rep < 2; rep++) begin
      add(1,1,0,0,0, 0,1,1,0,1);
      add(1,1,0,0,0, 0,0,2,0,1);
      add(1,1,0,0,0, 0,0,3,0,1);
      add(1,1,0,0,0, 0,0,4,0,1);
      add(1,1,0,0,0, 0,1,0,0,1);
    end
    add(1,1,1,4,1, 0,1,1,1,1);
    add(1,1,0,0,0, 0,0,2,1,1);
    add(1,1,0,0,0, 0,0,3,1,1);
    add(1,1,0,0,0, 0,0,4,1,1);
    add(1,1,0,0,0, 0,1,0,0,1);
    add(1,1,0,0,0, 0,1,1,0,1);
    add(1,1,0,0,0, 0,0,2,0,1);
    add(1,1,0,0,0, 0,0,3,0,1);
    add(1,1,0,0,0, 0,1,0,0,1);
    add(1,1,1,8,0, 0,1,1,1,1);
    add(1,1,0,0,0, 0,0,2,1,1);
    add(1,1,0,0,0, 0,0,3,1,1);
    add(1,1,0,0,0, 0,0,0,0,1);
    for (int k = 1; k <= 3; k++) add(1,1,0,0,0, 0,0,k,0,1);

    // Freeze at count=3 for 10 cycles; load D=3 while frozen restarts at 0.
    for (int k = 0; k < 10; k++) add(1,0,0,0,0, 0,0,3,0,1);
    add(1,0,1,3,0, 0,0,0,0,1);
    add(1,0,0,0,0, 0,0,0,0,1);
    for (int k = 1; k <= 2; k++) add(1,1,0,0,0, 0,0,k,0,1);
    add(1,1,0,0,0, 1,0,0,0,1);
    for (int k = 1; k <= 2; k++) add(1,1,0,0,0, 0,0,k,0,1);
    add(1,1,0,0,0, 1,0,0,0,1);

    // Square D=6 via freeze-apply, pend a load with clock_out high, then reset mid-period.
    add(1,0,1,6,1, 0,0,0,0,1);
    for (int k = 1; k <= 5; k++) add(1,1,0,0,0, 0,0,k,0,1);
    add(1,1,0,0,0, 0,1,0,0,1);
    add(1,1,1,9,0, 0,1,1,1,1);
    add(0,1,1,3,1, 0,0,0,0,0);
    for (int k = 1; k <= 4; k++) add(1,1,0,0,0, 0,0,k,0,0);
    add(1,1,0,0,0, 1,0,0,0,0);

    foreach (vecs[i]) begin
      reset      = vecs[i].rst_n;
      enable     = vecs[i].en;
      cfg_load   = vecs[i].ld;
      div_value  = vecs[i].div;
      mode_value = vecs[i].mode;
      step();
      chk_all(i, 32'(vecs[i].tick), 32'(vecs[i].clk), 32'(vecs[i].cnt),
              32'(vecs[i].pend), 32'(vecs[i].err));
    end

    // Load coinciding with terminal count: applied directly, never pending.
    reset    = 1'b1;
    enable   = 1'b1;
    cfg_load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_all(1000 + k, 0, 0, k, 0, 0);
    end
    cfg_load   = 1'b1;
    div_value  = W'(3);
    mode_value = 1'b0;
    step();
    chk_all(1005, 1, 0, 0, 0, 0);
    cfg_load = 1'b0;
    step();
    chk_all(1006, 0, 0, 1, 0, 0);
    step();
    chk_all(1007, 0, 0, 2, 0, 0);
    step();
    chk_all(1008, 1, 0, 0, 0, 0);

    // Zero divisor loaded while frozen: clamps to 2 immediately and flags the error.
    enable    = 1'b0;
    cfg_load  = 1'b1;
    div_value = '0;
    step();
    chk_all(2000, 0, 0, 0, 0, 1);
    cfg_load = 1'b0;
    enable   = 1'b1;
    step();
    chk_all(2001, 0, 0, 1, 0, 1);
    step();
    chk_all(2002, 1, 0, 0, 0, 1);
    step();
    chk_all(2003, 0, 0, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Runtime-programmable clock-enable generator; next generation of the fixed divide-by-100k block.
- Divides `clock` by a divisor loaded at run time (reset default set by parameter).
- Produces a one-cycle tick (pulse mode) or a near-50% level (square mode), both registered.
- Feeds slow-clock enables to the processor, display scan and debounce logic. Divisor and mode changes take effect glitch-free at period boundaries.

Parameters:
- WIDTH, 32, counter and divisor width in bits.
- DEFAULT_DIV, 100000, active divisor after reset; must be >= 2 and < 2**WIDTH.
- DEFAULT_MODE, 0, active mode after reset (0 = pulse, 1 = square).

Ports:
- clock  input  1  single system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  1 = count; 0 = freeze counter.
- div_value  input  WIDTH  requested divisor D.
- mode_value  input  1  requested mode.
- cfg_load  input  1  one-cycle strobe; captures div_value/mode_value into pending registers.
- tick_out  output  1  registered one-cycle pulse per period (pulse mode only).
- clock_out  output  1  registered divided level (square mode); 0 in pulse mode.
- count  output  WIDTH  current counter value, 0..D-1.
- cfg_pending  output  1  pending configuration not yet applied.
- cfg_err  output  1  sticky; set when a divisor < 2 was loaded.

Behaviour:
- Reset, sampled at posedge with reset==0:
  - count=0, active_div=DEFAULT_DIV, active_mode=DEFAULT_MODE.
  - pending cleared, cfg_pending=0, cfg_err=0, tick_out=0, clock_out=0.
  - Reset overrides cfg_load and enable in the same cycle; a mid-period reset abandons the period.
- Counter:
  - When enable=1: count increments each cycle. At terminal count (count==active_div-1) it wraps to 0.
  - When enable=0: count holds, tick_out=0, clock_out holds its level.
- Terminal count flag: tc = enable & (count==active_div-1). It is combinational and internal only.
- Pulse mode: tick_out<=tc, so tick_out is high for exactly one cycle, in the cycle after count==D-1. Period = D cycles when continuously enabled; latency 1 cycle.
- Square mode:
  - Define H = D>>1.
  - clock_out<=1 when enable & count==D-1 (rises in the cycle count==0).
  - clock_out<=0 when enable & count==H-1.
  - Result: high for H cycles, low for D-H cycles. Odd D gives low one cycle longer than high.
  - tick_out stays 0.
- Configuration capture:
  - cfg_load captures div_value/mode_value into pending and sets cfg_pending=1.
  - A later cfg_load before application overwrites pending (last wins).
- Divisor clamp: div_value 0 or 1 is captured as 2 and sets cfg_err. cfg_err clears only on reset.
- Configuration application (pending -> active, cfg_pending cleared):
  - On a tc cycle, so the new period starts with count=0.
  - Or on any cycle with enable=0, applied immediately.
- Simultaneous cfg_load and tc: the newly presented value is applied directly in that cycle and cfg_pending stays 0.
- Mode switch at a boundary:
  - Switching to pulse forces clock_out<=0.
  - Switching to square starts the next period with clock_out rising as per the normal rule.
- Divisor wrap guard: if active_div is reduced while count >= new D-1, this cannot occur, because application happens only at tc or while frozen. On freeze-apply, count is reset to 0.
- Arithmetic: all compares are unsigned at WIDTH bits. No overflow is possible since D <= 2**WIDTH-1.

Decomposition:
- Shared package clkdiv_pkg holds:
  - MODE_PULSE=1'b0 and MODE_SQUARE=1'b1.
  - MIN_DIV=2.
  - DEFAULT_DIV used by top level for the 1 kHz/1 Hz enables (100000, 100000000).
- One natural sub-module, clkdiv_cfg_shadow: pending/active register pair, clamp, cfg_err, and the apply logic.
- Counter and output logic stay in the top level.

Test Plan:
- Reset default with DEFAULT_DIV overridden to 5, pulse mode, enable=1 after reset release: tick_out high on cycles 5, 10, 15 (one cycle each); count sequence 0,1,2,3,4,0.
- cfg_load D=4 mid-period while D=6 running at count=2: cfg_pending=1; period completes at 6; next ticks spaced 4 cycles; cfg_pending drops on the tc cycle.
- Square mode D=5: clock_out pattern 1,1,0,0,0 repeating (H=2); D=4 gives 1,1,0,0.
- cfg_load D=1: active divisor becomes 2 at next boundary, cfg_err=1 and stays 1 through later valid loads until reset.
- enable=0 at count=3 (D=8) for 10 cycles: count holds 3, tick_out=0. cfg_load D=3 during freeze: applied immediately, count=0. After re-enable, ticks every 3 cycles.
- Reset low mid-period with cfg_pending=1 and clock_out=1: next cycle all outputs 0, count=0, pending discarded, DEFAULT_DIV active.
